// File: rtl/escalonador_rr_if.sv
// Scheduler <-> processor/OS bus: process creation, kill, PC hand-off and status.
interface escalonador_rr_if;
  localparam int unsigned PIDW = 3;
  localparam int unsigned QW   = 16;
  localparam int unsigned AW   = 32;

  logic            enable;
  logic [QW-1:0]   quantum;
  logic            create_req;
  logic [PIDW-1:0] create_pid;
  logic [AW-1:0]   create_pc;
  logic [AW-1:0]   create_base;
  logic            kill_req;
  logic [AW-1:0]   pc_atual;

  logic            halt;
  logic            load_pc;
  logic [AW-1:0]   new_pc;
  logic [AW-1:0]   deslocamento_memoria;
  logic [PIDW-1:0] pid_atual;
  logic            running;
  logic            create_err;

  modport master (
    output enable, quantum, create_req, create_pid, create_pc, create_base, kill_req, pc_atual,
    input  halt, load_pc, new_pc, deslocamento_memoria, pid_atual, running, create_err
  );

  modport slave (
    input  enable, quantum, create_req, create_pid, create_pc, create_base, kill_req, pc_atual,
    output halt, load_pc, new_pc, deslocamento_memoria, pid_atual, running, create_err
  );
endinterface

// File: rtl/escalonador_rr.sv
// Eight-slot round-robin process scheduler with per-slot saved PC and memory base.
module escalonador_rr (
  input  logic            clock_i,
  input  logic            reset_i,
  escalonador_rr_if.slave bus
);
  localparam int unsigned NSLOT = 8;
  localparam int unsigned PIDW  = 3;
  localparam int unsigned QW    = 16;
  localparam int unsigned AW    = 32;

  typedef enum logic [2:0] {IDLE, SELECT, RESTORE, RUN, SAVE} state_e;

  state_e          state_q, state_d;
  logic [QW-1:0]   cnt_q, cnt_d;
  logic            kill_q, kill_d;
  logic [NSLOT-1:0] valid_q;
  logic [AW-1:0]   pc_q   [NSLOT];
  logic [AW-1:0]   base_q [NSLOT];
  logic [PIDW-1:0] pid_q;
  logic [AW-1:0]   new_pc_q, desl_q;
  logic            halt_q, load_pc_q, running_q, create_err_q;

  logic            sel_found;
  logic [PIDW-1:0] sel_pid, cand;
  logic            clear_slot, save_slot, create_hit, create_fire;

  // Next valid slot after the current one; the current slot is checked last.
  always_comb begin
    sel_found = 1'b0;
    sel_pid   = pid_q;
    cand      = pid_q;
    for (int unsigned i = 1; i <= NSLOT; i++) begin
      cand = pid_q + PIDW'(i);
      if (!sel_found && valid_q[cand]) begin
        sel_found = 1'b1;
        sel_pid   = cand;
      end
    end
  end

  // A create to the slot being killed in this same cycle is allowed to win.
  always_comb begin
    clear_slot  = (state_q == SAVE) && kill_q;
    save_slot   = (state_q == SAVE) && !kill_q;
    create_hit  = valid_q[bus.create_pid] && !(clear_slot && (bus.create_pid == pid_q));
    create_fire = bus.create_req && !create_hit;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable && (|valid_q)) state_d = SELECT;
      end
      SELECT: begin
        state_d = (bus.enable && sel_found) ? RESTORE : IDLE;
      end
      RESTORE: begin
        cnt_d   = (bus.quantum == '0) ? QW'(1) : bus.quantum;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q - QW'(1);
        if (bus.kill_req || (cnt_q == QW'(1)) || !bus.enable) begin
          kill_d  = bus.kill_req;
          state_d = SAVE;
        end
      end
      SAVE: begin
        kill_d  = 1'b0;
        state_d = SELECT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      kill_q       <= 1'b0;
      valid_q      <= '0;
      pid_q        <= PIDW'(NSLOT - 1);
      new_pc_q     <= '0;
      desl_q       <= '0;
      halt_q       <= 1'b1;
      load_pc_q    <= 1'b0;
      running_q    <= 1'b0;
      create_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kill_q       <= kill_d;
      halt_q       <= (state_d != RUN);
      running_q    <= (state_d == RUN);
      load_pc_q    <= (state_d == RESTORE);
      create_err_q <= bus.create_req && create_hit;
      if (state_d == RESTORE) begin
        pid_q    <= sel_pid;
        new_pc_q <= pc_q[sel_pid];
        desl_q   <= base_q[sel_pid];
      end
      if (clear_slot)  valid_q[pid_q]          <= 1'b0;
      if (create_fire) valid_q[bus.create_pid] <= 1'b1;
    end
  end

  // Slot payload needs no reset: it is only observable once its valid bit is set.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      if (save_slot) pc_q[pid_q] <= bus.pc_atual;
      if (create_fire) begin
        pc_q[bus.create_pid]   <= bus.create_pc;
        base_q[bus.create_pid] <= bus.create_base;
      end
    end
  end

  assign bus.halt                 = halt_q;
  assign bus.load_pc              = load_pc_q;
  assign bus.new_pc               = new_pc_q;
  assign bus.deslocamento_memoria = desl_q;
  assign bus.pid_atual            = pid_q;
  assign bus.running              = running_q;
  assign bus.create_err           = create_err_q;
endmodule

// File: tb/tb_escalonador_rr.sv
// Self-checking bench for escalonador_rr: directed scenarios plus random traffic against a reference model.
module tb_escalonador_rr;
  logic clk = 1'b0;
  logic rst;

  escalonador_rr_if bus ();

  escalonador_rr dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  localparam int M_IDLE = 0, M_SELECT = 1, M_RESTORE = 2, M_RUN = 3, M_SAVE = 4;

  int          m_phase, m_left, m_pid;
  bit          m_kill;
  bit          m_valid [8];
  logic [31:0] m_pc    [8];
  logic [31:0] m_base  [8];
  bit          m_halt, m_load, m_run, m_err;
  logic [31:0] m_newpc, m_desl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit any_valid();
    for (int k = 0; k < 8; k++) if (m_valid[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int next_valid();
    for (int k = 1; k <= 8; k++) if (m_valid[(m_pid + k) % 8]) return (m_pid + k) % 8;
    return -1;
  endfunction

  // Reference model: advanced once per rising edge with the inputs seen at that edge.
  task automatic model_step();
    int nxt, cp;
    bit clearing, fire;
    if (rst) begin
      m_phase = M_IDLE; m_left = 0; m_pid = 7; m_kill = 1'b0;
      for (int k = 0; k < 8; k++) m_valid[k] = 1'b0;
      m_halt = 1'b1; m_load = 1'b0; m_run = 1'b0; m_err = 1'b0;
      m_newpc = '0; m_desl = '0;
      return;
    end
    cp       = int'(bus.create_pid);
    clearing = (m_phase == M_SAVE) && m_kill && (cp == m_pid);
    fire     = bus.create_req && (!m_valid[cp] || clearing);
    m_err    = bus.create_req && !fire;
    m_load   = 1'b0;
    case (m_phase)
      M_IDLE: if (bus.enable && any_valid()) m_phase = M_SELECT;
      M_SELECT: begin
        nxt = next_valid();
        if (bus.enable && nxt >= 0) begin
          m_pid = nxt; m_newpc = m_pc[nxt]; m_desl = m_base[nxt];
          m_load = 1'b1; m_phase = M_RESTORE;
        end else m_phase = M_IDLE;
      end
      M_RESTORE: begin
        m_left  = (bus.quantum == 16'd0) ? 1 : int'(bus.quantum);
        m_phase = M_RUN;
      end
      M_RUN: begin
        m_left--;
        if (bus.kill_req || m_left == 0 || !bus.enable) begin
          m_kill = bus.kill_req; m_phase = M_SAVE;
        end
      end
      default: begin
        if (m_kill) m_valid[m_pid] = 1'b0;
        else        m_pc[m_pid]    = bus.pc_atual;
        m_kill  = 1'b0;
        m_phase = M_SELECT;
      end
    endcase
    if (fire) begin
      m_valid[cp] = 1'b1; m_pc[cp] = bus.create_pc; m_base[cp] = bus.create_base;
    end
    m_halt = (m_phase != M_RUN);
    m_run  = (m_phase == M_RUN);
  endtask

  task automatic compare_all();
    chk("halt",       32'(bus.halt),       32'(m_halt));
    chk("load_pc",    32'(bus.load_pc),    32'(m_load));
    chk("running",    32'(bus.running),    32'(m_run));
    chk("create_err", 32'(bus.create_err), 32'(m_err));
    chk("pid_atual",  32'(bus.pid_atual),  32'(m_pid));
    chk("new_pc",     bus.new_pc,               m_newpc);
    chk("desloc",     bus.deslocamento_memoria, m_desl);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.create_req = 1'b0; bus.kill_req = 1'b0; bus.enable = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  task automatic create(input int pid, input logic [31:0] pc, input logic [31:0] base);
    bus.create_req = 1'b1; bus.create_pid = 3'(pid); bus.create_pc = pc; bus.create_base = base;
    cycle();
    bus.create_req = 1'b0;
  endtask

  task automatic wait_running(output int gap);
    gap = 0;
    while (!bus.running && gap < 50) begin gap++; cycle(); end
    if (!bus.running) chk("run_timeout", 32'(bus.running), 32'd1);
  endtask

  task automatic count_run(output int len);
    len = 0;
    while (bus.running && len < 100) begin len++; cycle(); end
    if (bus.running) chk("run_overflow", 32'(bus.running), 32'd0);
  endtask

  initial begin
    int gap, len, seen;
    int exp_seq [4] = '{0, 3, 5, 0};
    rst = 1'b1; bus.enable = 1'b0; bus.quantum = 16'd4; bus.create_req = 1'b0;
    bus.create_pid = '0; bus.create_pc = '0; bus.create_base = '0;
    bus.kill_req = 1'b0; bus.pc_atual = '0;

    // Single process: first dispatch, slice length, switch cost, PC restore.
    do_reset();
    chk("rst_pid", 32'(bus.pid_atual), 32'd7);
    create(2, 32'h40, 32'h100);
    bus.quantum = 16'd4; bus.pc_atual = 32'h1234; bus.enable = 1'b1;
    wait_running(gap);
    chk("s1_newpc", bus.new_pc, 32'h40);
    chk("s1_desl",  bus.deslocamento_memoria, 32'h100);
    chk("s1_pid",   32'(bus.pid_atual), 32'd2);
    count_run(len);  chk("s1_len", 32'(len), 32'd4);
    wait_running(gap); chk("s1_gap", 32'(gap), 32'd3);
    chk("s1_repc", bus.new_pc, 32'h1234);
    chk("s1_repid", 32'(bus.pid_atual), 32'd2);

    // Round robin over slots 0, 3, 5.
    do_reset();
    create(0, 32'h1000, 32'h0); create(3, 32'h3000, 32'h300); create(5, 32'h5000, 32'h500);
    bus.quantum = 16'd2; bus.enable = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wait_running(gap);
      chk("rr_pid", 32'(bus.pid_atual), 32'(exp_seq[s]));
      count_run(len); chk("rr_len", 32'(len), 32'd2);
    end

    // Kill mid-slice: slot 1 never runs again.
    do_reset();
    create(1, 32'h11, 32'h1100); create(4, 32'h44, 32'h4400);
    bus.quantum = 16'd8; bus.enable = 1'b1;
    wait_running(gap); chk("k_pid", 32'(bus.pid_atual), 32'd1);
    cycle(); cycle();
    bus.kill_req = 1'b1; cycle(); bus.kill_req = 1'b0;
    for (int s = 0; s < 3; s++) begin
      wait_running(gap); chk("k_next", 32'(bus.pid_atual), 32'd4);
      count_run(len); chk("k_len", 32'(len), 32'd8);
    end

    // Kill on the only RUN cycle of a 1-cycle slice, last process -> idle.
    do_reset();
    create(6, 32'h66, 32'h600);
    bus.quantum = 16'd1; bus.enable = 1'b1;
    wait_running(gap);
    bus.kill_req = 1'b1; cycle(); bus.kill_req = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin cycle(); if (bus.running) seen = 1; end
    chk("kx_no_run", 32'(seen), 32'd0);
    chk("kx_halt", 32'(bus.halt), 32'd1);

    // Duplicate create and zero quantum.
    do_reset();
    create(3, 32'hA0, 32'h10);
    chk("ce_none", 32'(bus.create_err), 32'd0);
    create(3, 32'hB0, 32'h20);
    chk("ce_pulse", 32'(bus.create_err), 32'd1);
    cycle(); chk("ce_clear", 32'(bus.create_err), 32'd0);
    bus.quantum = 16'd0; bus.enable = 1'b1;
    for (int s = 0; s < 2; s++) begin
      wait_running(gap); count_run(len); chk("q0_len", 32'(len), 32'd1);
    end
    chk("ce_keep_base", bus.deslocamento_memoria, 32'h10);

    // Reset while in SAVE.
    do_reset();
    create(2, 32'h22, 32'h200); create(7, 32'h77, 32'h700);
    bus.quantum = 16'd3; bus.enable = 1'b1;
    wait_running(gap); count_run(len);
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("mr_halt", 32'(bus.halt), 32'd1);
    chk("mr_pid",  32'(bus.pid_atual), 32'd7);
    chk("mr_npc",  bus.new_pc, 32'd0);
    chk("mr_desl", bus.deslocamento_memoria, 32'd0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin cycle(); if (bus.running || bus.load_pc) seen = 1; end
    chk("mr_no_restart", 32'(seen), 32'd0);

    // Random traffic checked cycle-by-cycle against the model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rst             = ($urandom_range(0, 199) == 0);
      bus.enable      = ($urandom_range(0, 9) != 0);
      bus.quantum     = 16'($urandom_range(0, 5));
      bus.create_req  = ($urandom_range(0, 7) == 0);
      bus.create_pid  = 3'($urandom_range(0, 7));
      bus.create_pc   = $urandom;
      bus.create_base = $urandom;
      bus.kill_req    = ($urandom_range(0, 9) == 0);
      bus.pc_atual    = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
